// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the instruction sequencer: state encoding,
// RV32-style major opcodes, fault codes and the default memory timeout.
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_t;

    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    localparam int MEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/cpu_sequencer_op_class_decode.sv
// Combinational opcode classifier: exactly one class flag is set for any opcode.
module op_class_decode
    import seq_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       is_alu,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_system,
    output logic       is_illegal
);

    // Map the major opcode onto its instruction class
    always_comb begin
        is_alu     = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_branch  = 1'b0;
        is_system  = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_ALU_R, OP_ALU_I: is_alu    = 1'b1;
            OP_LOAD:            is_load   = 1'b1;
            OP_STORE:           is_store  = 1'b1;
            OP_BRANCH:          is_branch = 1'b1;
            OP_SYSTEM:          is_system = 1'b1;
            default:            is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: steps each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and stops in HALT on SYSTEM or fault.
module cpu_sequencer
    import seq_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        imem_valid,
    input  logic        dmem_ready,
    output logic        ir_we,
    output logic        exec_en,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        halted,
    output logic [1:0]  fault,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    // Counter only needs to reach MEM_TIMEOUT-1: the cycle it would hit
    // MEM_TIMEOUT is the cycle the FSM leaves for HALT.
    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [6:0]    r_op;
    logic [31:0]   r_retired;
    logic [CW-1:0] r_wait_cnt;
    logic [1:0]    r_fault;
    logic [1:0]    w_fault_next;
    logic          w_retire;

    logic w_is_alu, w_is_load, w_is_store, w_is_branch, w_is_system, w_is_illegal;
    logic w_op_load, w_op_store, w_op_branch;

    op_class_decode u_op_class_decode (
        .opcode     (opcode),
        .is_alu     (w_is_alu),
        .is_load    (w_is_load),
        .is_store   (w_is_store),
        .is_branch  (w_is_branch),
        .is_system  (w_is_system),
        .is_illegal (w_is_illegal)
    );

    // Class of the latched instruction, used after DECODE
    assign w_op_load   = (r_op == OP_LOAD);
    assign w_op_store  = (r_op == OP_STORE);
    assign w_op_branch = (r_op == OP_BRANCH);

    // Next-state, fault update and strobe generation
    always_comb begin
        w_next_state = r_state;
        w_fault_next = r_fault;
        w_retire     = 1'b0;
        ir_we        = 1'b0;
        exec_en      = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_we       = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_FETCH: begin
                ir_we = imem_valid;
                if (imem_valid) begin
                    w_next_state = ST_DECODE;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (w_is_system) begin
                    w_next_state = ST_HALT;
                end else if (w_is_illegal) begin
                    w_next_state = ST_HALT;
                    w_fault_next = FAULT_ILLEGAL;
                end else if (w_is_alu | w_is_load | w_is_store | w_is_branch) begin
                    w_next_state = ST_EXECUTE;
                end else begin
                    w_next_state = ST_HALT;
                    w_fault_next = FAULT_ILLEGAL;
                end
            end
            ST_EXECUTE: begin
                exec_en = 1'b1;
                if (w_op_load | w_op_store) begin
                    w_next_state = ST_MEMORY;
                end else if (w_op_branch) begin
                    pc_we        = 1'b1;
                    pc_src       = branch_taken;
                    w_retire     = 1'b1;
                    w_next_state = run ? ST_FETCH : ST_IDLE;
                end else begin
                    w_next_state = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                mem_read  = w_op_load;
                mem_write = w_op_store;
                if (dmem_ready) begin
                    if (w_op_load) begin
                        w_next_state = ST_WRITEBACK;
                    end else begin
                        pc_we        = 1'b1;
                        w_retire     = 1'b1;
                        w_next_state = run ? ST_FETCH : ST_IDLE;
                    end
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_next_state = ST_HALT;
                    w_fault_next = FAULT_TIMEOUT;
                end else begin
                    w_next_state = ST_MEMORY;
                end
            end
            ST_WRITEBACK: begin
                reg_we       = 1'b1;
                pc_we        = 1'b1;
                w_retire     = 1'b1;
                w_next_state = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_HALT;
            end
        endcase
    end

    // State register, opcode latch, sticky fault and retired counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_op      <= 7'd0;
            r_fault   <= FAULT_NONE;
            r_retired <= 32'd0;
        end else begin
            r_state <= w_next_state;
            r_fault <= w_fault_next;
            if (r_state == ST_DECODE) begin
                r_op <= opcode;
            end
            if (w_retire) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    // MEMORY wait counter: zero outside MEMORY, so every entry starts fresh
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_MEMORY) begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign state   = r_state;
    assign halted  = (r_state == ST_HALT);
    assign fault   = r_fault;
    assign retired = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer (MEM_TIMEOUT=4): every cycle of each
// scenario is compared against hand-derived state and strobe values.
module tb_cpu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        imem_valid;
    logic        dmem_ready;
    logic        ir_we, exec_en, mem_read, mem_write, reg_we, pc_we, pc_src, halted;
    logic [1:0]  fault;
    logic [2:0]  state;
    logic [31:0] retired;

    int checks   = 0;
    int failures = 0;

    cpu_sequencer #(.MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .imem_valid   (imem_valid),
        .dmem_ready   (dmem_ready),
        .ir_we        (ir_we),
        .exec_en      (exec_en),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg_we       (reg_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .halted       (halted),
        .fault        (fault),
        .state        (state),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // strobe vector order: ir_we exec_en mem_read mem_write reg_we pc_we pc_src
    task automatic chk_cyc(input string tag, input logic [2:0] st, input logic [6:0] sb);
        chk(tag, {22'd0, state, ir_we, exec_en, mem_read, mem_write, reg_we, pc_we, pc_src},
            {22'd0, st, sb});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [6:0] SB_NONE  = 7'b0000000;
    localparam logic [6:0] SB_FETCH = 7'b1000000;
    localparam logic [6:0] SB_EXEC  = 7'b0100000;
    localparam logic [6:0] SB_WB    = 7'b0000110;
    localparam logic [6:0] SB_BR_T  = 7'b0100011;
    localparam logic [6:0] SB_MRD   = 7'b0010000;
    localparam logic [6:0] SB_MWR   = 7'b0001000;
    localparam logic [6:0] SB_MWR_D = 7'b0001010;

    initial begin
        rst_n = 1'b0; run = 1'b0; opcode = 7'd0; branch_taken = 1'b0;
        imem_valid = 1'b0; dmem_ready = 1'b0;
        #1;
        chk_cyc("reset_state", 3'd0, SB_NONE);
        chk("reset_retired", retired, 32'd0);
        chk("reset_fault", {30'd0, fault}, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;

        // ALU instruction: 1,2,3,5 then back to FETCH
        run = 1'b1; opcode = 7'b0110011; imem_valid = 1'b1;
        #1; chk_cyc("alu_idle", 3'd0, SB_NONE);
        tick(); chk_cyc("alu_fetch", 3'd1, SB_FETCH);
        tick(); chk_cyc("alu_decode", 3'd2, SB_NONE);
        tick(); chk_cyc("alu_exec", 3'd3, SB_EXEC);
        tick(); chk_cyc("alu_wb", 3'd5, SB_WB);
        chk("alu_ret_before", retired, 32'd0);
        // Branch taken follows
        opcode = 7'b1100011; branch_taken = 1'b1;
        tick(); #1; chk_cyc("alu_refetch", 3'd1, SB_FETCH);
        chk("alu_ret_after", retired, 32'd1);
        tick(); chk_cyc("br_decode", 3'd2, SB_NONE);
        tick(); chk_cyc("br_exec", 3'd3, SB_BR_T);
        chk("br_ret_before", retired, 32'd1);
        // Load, dmem_ready on the fourth MEMORY cycle
        opcode = 7'b0000011; branch_taken = 1'b0;
        tick(); #1; chk_cyc("br_refetch", 3'd1, SB_FETCH);
        chk("br_ret_after", retired, 32'd2);
        tick(); chk_cyc("ld_decode", 3'd2, SB_NONE);
        tick(); chk_cyc("ld_exec", 3'd3, SB_EXEC);
        tick(); chk_cyc("ld_mem1", 3'd4, SB_MRD);
        tick(); chk_cyc("ld_mem2", 3'd4, SB_MRD);
        tick(); chk_cyc("ld_mem3", 3'd4, SB_MRD);
        tick(); dmem_ready = 1'b1; #1; chk_cyc("ld_mem4", 3'd4, SB_MRD);
        tick(); dmem_ready = 1'b0; opcode = 7'b0100011; #1;
        chk_cyc("ld_wb", 3'd5, SB_WB);
        chk("ld_ret_wb", retired, 32'd2);
        tick(); chk_cyc("ld_refetch", 3'd1, SB_FETCH);
        chk("ld_ret_after", retired, 32'd3);

        // Store with run dropped mid-MEMORY and retired at the wrap point
        tick(); chk_cyc("st_decode", 3'd2, SB_NONE);
        tick(); chk_cyc("st_exec", 3'd3, SB_EXEC);
        tick(); run = 1'b0;
        force dut.r_retired = 32'hFFFF_FFFF;
        #1; release dut.r_retired;
        #1; chk_cyc("st_mem1", 3'd4, SB_MWR);
        chk("st_ret_preload", retired, 32'hFFFF_FFFF);
        tick(); dmem_ready = 1'b1; #1; chk_cyc("st_mem_done", 3'd4, SB_MWR_D);
        tick(); dmem_ready = 1'b0; #1; chk_cyc("st_to_idle", 3'd0, SB_NONE);
        chk("st_ret_wrap", retired, 32'd0);
        tick(); chk_cyc("st_idle_hold", 3'd0, SB_NONE);

        // Reset asserted mid-MEMORY drops mem_read with no clock edge
        run = 1'b1; opcode = 7'b0000011;
        tick(); chk_cyc("rst_fetch", 3'd1, SB_FETCH);
        tick(); chk_cyc("rst_decode", 3'd2, SB_NONE);
        tick(); chk_cyc("rst_exec", 3'd3, SB_EXEC);
        tick(); chk_cyc("rst_mem", 3'd4, SB_MRD);
        #2; rst_n = 1'b0;
        #1; chk_cyc("rst_async", 3'd0, SB_NONE);
        tick(); rst_n = 1'b1;

        // Store timeout: HALT after 4 MEMORY cycles, fault=10
        opcode = 7'b0100011;
        #1; chk_cyc("to_idle", 3'd0, SB_NONE);
        tick(); chk_cyc("to_fetch", 3'd1, SB_FETCH);
        tick(); chk_cyc("to_decode", 3'd2, SB_NONE);
        tick(); chk_cyc("to_exec", 3'd3, SB_EXEC);
        tick(); chk_cyc("to_mem1", 3'd4, SB_MWR);
        tick(); chk_cyc("to_mem2", 3'd4, SB_MWR);
        tick(); chk_cyc("to_mem3", 3'd4, SB_MWR);
        tick(); chk_cyc("to_mem4", 3'd4, SB_MWR);
        chk("to_fault_pending", {30'd0, fault}, 32'd0);
        tick(); chk_cyc("to_halt", 3'd6, SB_NONE);
        chk("to_fault", {30'd0, fault}, 32'h2);
        chk("to_halted", {31'd0, halted}, 32'd1);
        chk("to_retired", retired, 32'd0);
        dmem_ready = 1'b1;
        tick(); chk_cyc("to_halt_hold", 3'd6, SB_NONE);
        chk("to_fault_hold", {30'd0, fault}, 32'h2);
        dmem_ready = 1'b0;

        // Illegal opcode: HALT from DECODE with fault=01
        rst_n = 1'b0; #1;
        chk("ill_rst_fault", {30'd0, fault}, 32'd0);
        tick(); rst_n = 1'b1; opcode = 7'b1111111;
        tick(); chk_cyc("ill_fetch", 3'd1, SB_FETCH);
        tick(); chk_cyc("ill_decode", 3'd2, SB_NONE);
        tick(); chk_cyc("ill_halt", 3'd6, SB_NONE);
        chk("ill_fault", {30'd0, fault}, 32'h1);
        chk("ill_halted", {31'd0, halted}, 32'd1);

        // SYSTEM opcode after reset: HALT with fault=00
        rst_n = 1'b0; #1;
        tick(); rst_n = 1'b1; opcode = 7'b1110011;
        tick(); chk_cyc("sys_fetch", 3'd1, SB_FETCH);
        tick(); chk_cyc("sys_decode", 3'd2, SB_NONE);
        tick(); chk_cyc("sys_halt", 3'd6, SB_NONE);
        chk("sys_fault", {30'd0, fault}, 32'd0);
        chk("sys_halted", {31'd0, halted}, 32'd1);
        tick(); chk_cyc("sys_halt_hold", 3'd6, SB_NONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, meaning max MEMORY-state wait cycles before fault.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  enable instruction sequencing
- opcode  in  7  instr[6:0] from instruction register, sampled in DECODE
- branch_taken  in  1  branch outcome from execute stage, sampled in EXECUTE
- imem_valid  in  1  fetch data valid
- dmem_ready  in  1  data memory access complete
- ir_we  out  1  load instruction register
- exec_en  out  1  execute stage operands and result valid this cycle
- mem_read  out  1  data memory read request
- mem_write  out  1  data memory write request
- reg_we  out  1  register file write enable
- pc_we  out  1  PC update strobe
- pc_src  out  1  0 = PC+4, 1 = branch_target
- halted  out  1  HALT state reached
- fault  out  2  00 none, 01 illegal opcode, 10 memory timeout, 11 reserved (never driven)
- state  out  3  current state encoding
- retired  out  32  retired-instruction count

Function
REQ-003 States and encoding SHALL be: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6; code 7 SHALL be unreachable and SHALL transition to HALT.
REQ-004 IDLE: if run=1 -> FETCH next cycle; otherwise remain in IDLE.
REQ-005 FETCH: ir_we=imem_valid; if imem_valid=1 -> DECODE; otherwise remain in FETCH, with no timeout.
REQ-006 DECODE (1 cycle): latch opcode into internal op_q.
- 0110011, 0010011, 0000011, 0100011, 1100011 -> EXECUTE.
- 1110011 -> HALT with fault=00.
- any other value -> HALT with fault=01.
REQ-007 EXECUTE (1 cycle): exec_en=1.
- LOAD/STORE -> MEMORY.
- BRANCH -> instruction end, pc_we=1, pc_src=branch_taken.
- R/I ALU -> WRITEBACK.
REQ-008 MEMORY:
- mem_read=1 for LOAD, mem_write=1 for STORE, held until dmem_ready=1.
- On dmem_ready=1: LOAD -> WRITEBACK; STORE -> instruction end, pc_we=1, pc_src=0.
- Wait counter resets on MEMORY entry; if dmem_ready=0 for MEM_TIMEOUT consecutive cycles -> HALT with fault=10, no pc_we.
REQ-009 WRITEBACK (1 cycle): reg_we=1, pc_we=1, pc_src=0; instruction end.
REQ-010 Instruction end: retired increments by 1 (wraps 0xFFFFFFFF -> 0); next state FETCH if run=1, else IDLE.
REQ-011 run SHALL be sampled only in IDLE and at instruction end; deasserting run mid-instruction SHALL NOT abort the instruction.
REQ-012 HALT: all strobes 0, halted=1, fault held; leaves only by reset; ignores run.
REQ-013 All strobes (ir_we, exec_en, mem_read, mem_write, reg_we, pc_we) SHALL be combinational from state, op_q and the ready/valid inputs, with at most one of reg_we/mem_write asserted per cycle.
REQ-014 pc_src SHALL be 0 whenever pc_we=0.

Reset
REQ-015 On rst_n=0, asynchronously: state=IDLE, op_q=0, retired=0, wait counter=0, fault=00, halted=0, all strobes 0.
REQ-016 Reset mid-MEMORY SHALL drop mem_read/mem_write immediately, without waiting for a clock edge.

Structure
REQ-017 Package seq_ctrl_pkg SHALL hold the state encoding, opcode constants, fault codes and the MEM_TIMEOUT default.
REQ-018 Opcode classification SHALL be a combinational sub-module op_class_decode (opcode -> is_alu, is_load, is_store, is_branch, is_system, is_illegal), used in DECODE.

Verification
REQ-019 Bench SHALL cover:
- ALU: run=1, opcode 0110011, imem_valid immediate -> states 1,2,3,5,1; reg_we pulse in WRITEBACK; retired 0->1.
- Branch: opcode 1100011, branch_taken=1 -> pc_we=1, pc_src=1 on the EXECUTE cycle; reg_we never asserted; retired increments.
- Load with dmem_ready after 3 cycles -> mem_read high exactly 4 cycles, then WRITEBACK, then FETCH.
- Store, dmem_ready never asserted, MEM_TIMEOUT=4 -> HALT after 4 MEMORY cycles; fault=10; retired unchanged; mem_write deasserts.
- Opcode 1111111 -> HALT from DECODE with fault=01; then opcode 1110011 after reset -> HALT with fault=00.
- run deasserted during MEMORY -> instruction completes, then IDLE; retired preloaded to 0xFFFFFFFF wraps to 0; rst_n low mid-MEMORY clears mem_read with no clock edge.
